tm1638_resp: RTL and testbench
==============================

# tm1638_resp

Synchronous responder that plays the TM1638 side of the STB/CLK/DIO serial link. It decodes data, address and display-control commands into a 16-byte display RAM and display settings, and returns a 4-byte key-scan stream on read commands. It is the loop-back and bench partner for the LED/KEY driver, and also serves as a chip stand-in on boards without a TM1638. All logic runs on CK_i; the link pins are oversampled.

## Interface
- C_SYNC_N, 2: synchronizer depth on SS_i/SCLK_i/MOSI_i; minimum 2.
- CK_i  in  1  system clock; all logic on rising edge
- XARST_i  in  1  reset, asynchronous, active-low
- SS_i  in  1  STB from master, active-low frame
- SCLK_i  in  1  CLK from master, idles high
- MOSI_i  in  1  DIO as driven by master
- MISO_o  out  1  DIO value driven by responder
- MISO_EN_o  out  1  DIO drive enable
- KEYSCAN_i  in  32  key-scan bytes; byte j = KEYSCAN_i[8j+7:8j], j=0..3
- DISP_RAM_o  out  128  display RAM; address a = DISP_RAM_o[8a+7:8a]
- DISP_ON_o  out  1  display enable (control bit3)
- BRIGHT_o  out  3  brightness (control bits2:0)
- RD_MODE_o  out  1  current data-command read flag
- UPD_o  out  1  one-cycle pulse at frame end if RAM or control changed

## Operation
- Pins pass through C_SYNC_N flops, then one edge-detect flop. Internal events: ss_fall, ss_rise, sck_rise, sck_fall.
- Bits are LSB-first. A MOSI bit is sampled on sck_rise. Bit counter is 3 bits and wraps 7->0; a byte completes on the 8th sck_rise.
- States:
  - S_IDLE: SS high.
  - S_CMD: ss_fall enters here; bit counter clears.
  - S_WDATA, S_RDATA, S_IGNORE: described below.
  - ss_rise in any state goes to S_IDLE. A partial byte is discarded and MISO_EN_o goes to 0.
- Command decode at S_CMD byte complete (cmd[7:6]):
  - 01, data command: rd_mode<=cmd[1], fixed<=cmd[2]; cmd[3] (test) is ignored. If cmd[1]=1, go to S_RDATA; otherwise go to S_IGNORE.
  - 11, address command: addr<=cmd[3:0]. If rd_mode=0, go to S_WDATA; otherwise go to S_IGNORE.
  - 10, display control: DISP_ON_o<=cmd[3], BRIGHT_o<=cmd[2:0], mark changed; go to S_IGNORE.
  - 00: ignored; go to S_IGNORE.
- S_WDATA: each completed byte writes RAM[addr] and marks changed. If fixed=0, addr increments mod 16 (15 wraps to 0). If fixed=1, addr holds. Unlimited bytes per frame are accepted.
- S_RDATA:
  - On entry, KEYSCAN_i is captured into a 32-bit shift register, MISO_EN_o<=1, MISO_o<=1.
  - Each sck_fall presents the next bit: fall 1 gives byte0 bit0, and so on through fall 32 giving byte3 bit7.
  - Fall 33 and later: MISO_EN_o<=0, MISO_o<=1.
  - MOSI is ignored in this state.
- S_IGNORE: bits are clocked and discarded.
- rd_mode, fixed and addr persist across frames until rewritten.
- UPD_o pulses for one cycle on ss_rise when changed is set; changed then clears. A write of an identical value still counts as changed.

## Timing
- Reset values:
  - MISO_o=1, MISO_EN_o=0, DISP_RAM_o=0, DISP_ON_o=0, BRIGHT_o=0, RD_MODE_o=0, UPD_o=0.
  - Internal: addr=0, fixed=0, state S_IDLE.
- Pin edge to internal event latency is C_SYNC_N+1 CK cycles. Outputs register one cycle after the event.
  - With C_SYNC_N=2: a DISP_RAM_o byte updates 4 cycles after the 8th SCLK rise.
  - MISO_o updates 4 cycles after an SCLK fall.
  - UPD_o fires 4 cycles after the SS rise.
- Required pin timing: SCLK high and low phases each ≥ C_SYNC_N+3 CK cycles. SS setup to the first SCLK fall, and SCLK last rise to SS rise, each ≥ C_SYNC_N+2 cycles.
- Simultaneous ss_rise and byte-complete in the same cycle: ss_rise wins and the byte is discarded.
- SS toggling while SCLK is low is legal; a new frame always restarts at S_CMD.
- XARST_i assertion mid-frame forces reset values immediately. After release, the responder waits for the next ss_fall; if SS is already low, the frame is ignored until SS goes high.

## Test plan
- Reset: hold XARST_i low while toggling pins -> all outputs at their reset values, MISO_EN_o=0 throughout.
- Auto-increment write: frame 0x40; frame 0xCE,0x11,0x22,0x33 -> RAM[14]=0x11, RAM[15]=0x22, RAM[0]=0x33, other bytes 0, UPD_o one pulse per frame.
- Fixed-address write: frame 0x44; frame 0xC3,0xAA,0x55 -> RAM[3]=0x55 only, RAM[4]=0.
- Display control: frame 0x8D -> DISP_ON_o=1, BRIGHT_o=5, one UPD_o pulse. Frame 0x80 -> DISP_ON_o=0, BRIGHT_o=0.
- Key read: KEYSCAN_i=0x8421_0F01, frame 0x42 with 40 clocks:
  - sampled on SCLK rises 1-32: 0x01, 0x0F, 0x21, 0x84 (LSB-first);
  - MISO_EN_o=0 after fall 33;
  - KEYSCAN_i changed mid-read does not alter the stream;
  - RD_MODE_o=1, and a following 0xC0,0xFF frame leaves the RAM unchanged.
- Abort: SS rises after 5 bits of a 0xC0 data byte -> no RAM write, MISO_EN_o=0. The next 0x40 frame plus a 0xC1,0x77 frame writes RAM[1]=0x77.

Source files
------------

// File: rtl/tm1638_resp.sv
// TM1638-side responder for the STB/CLK/DIO link: decodes commands into a
// 16-byte display RAM and display settings, and streams key-scan bytes on reads.
module tm1638_resp #(
    parameter int C_SYNC_N = 2
) (
    input  logic         CK_i,
    input  logic         XARST_i,
    input  logic         SS_i,
    input  logic         SCLK_i,
    input  logic         MOSI_i,
    output logic         MISO_o,
    output logic         MISO_EN_o,
    input  logic [31:0]  KEYSCAN_i,
    output logic [127:0] DISP_RAM_o,
    output logic         DISP_ON_o,
    output logic [2:0]   BRIGHT_o,
    output logic         RD_MODE_o,
    output logic         UPD_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_t;

    logic [C_SYNC_N-1:0] ss_sync_q;
    logic [C_SYNC_N-1:0] sck_sync_q;
    logic [C_SYNC_N-1:0] mosi_sync_q;
    logic                ss_prev_q;
    logic                sck_prev_q;
    logic                ss_fall_q;
    logic                ss_rise_q;
    logic                sck_rise_q;
    logic                sck_fall_q;
    logic                mosi_q;

    logic                ss_s;
    logic                sck_s;
    logic                mosi_s;

    assign ss_s   = ss_sync_q[C_SYNC_N-1];
    assign sck_s  = sck_sync_q[C_SYNC_N-1];
    assign mosi_s = mosi_sync_q[C_SYNC_N-1];

    // SS synchronizer resets low so a frame already in progress at reset
    // release produces no ss_fall; the responder then waits for SS high.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            ss_sync_q   <= '0;
            sck_sync_q  <= '1;
            mosi_sync_q <= '0;
            ss_prev_q   <= 1'b0;
            sck_prev_q  <= 1'b1;
            ss_fall_q   <= 1'b0;
            ss_rise_q   <= 1'b0;
            sck_rise_q  <= 1'b0;
            sck_fall_q  <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[C_SYNC_N-2:0], SS_i};
            sck_sync_q  <= {sck_sync_q[C_SYNC_N-2:0], SCLK_i};
            mosi_sync_q <= {mosi_sync_q[C_SYNC_N-2:0], MOSI_i};
            ss_prev_q   <= ss_s;
            sck_prev_q  <= sck_s;
            ss_fall_q   <= ss_prev_q & ~ss_s;
            ss_rise_q   <= ~ss_prev_q & ss_s;
            sck_rise_q  <= ~sck_prev_q & sck_s;
            sck_fall_q  <= sck_prev_q & ~sck_s;
            mosi_q      <= mosi_s;
        end
    end

    state_t       state_q;
    logic [2:0]   bitcnt_q;
    logic [7:0]   sh_q;
    logic [3:0]   addr_q;
    logic         fixed_q;
    logic         rd_mode_q;
    logic         changed_q;
    logic         upd_q;
    logic [127:0] ram_q;
    logic         disp_on_q;
    logic [2:0]   bright_q;
    logic [31:0]  ks_q;
    logic [5:0]   fall_cnt_q;
    logic         miso_q;
    logic         miso_en_q;

    logic [7:0]   byte_d;
    logic         byte_done;
    logic [6:0]   ram_idx;

    // LSB-first: new bit enters at the top, so after 8 shifts bit0 is the first bit.
    assign byte_d    = {mosi_q, sh_q[7:1]};
    assign byte_done = sck_rise_q && (bitcnt_q == 3'd7);
    assign ram_idx   = {addr_q, 3'b000};

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state_q    <= S_IDLE;
            bitcnt_q   <= 3'd0;
            sh_q       <= 8'h00;
            addr_q     <= 4'd0;
            fixed_q    <= 1'b0;
            rd_mode_q  <= 1'b0;
            changed_q  <= 1'b0;
            upd_q      <= 1'b0;
            ram_q      <= '0;
            disp_on_q  <= 1'b0;
            bright_q   <= 3'd0;
            ks_q       <= 32'h0;
            fall_cnt_q <= 6'd0;
            miso_q     <= 1'b1;
            miso_en_q  <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (ss_rise_q) begin
                // Frame end takes priority over a byte completing in the same cycle.
                state_q   <= S_IDLE;
                miso_en_q <= 1'b0;
                miso_q    <= 1'b1;
                if (changed_q) begin
                    upd_q     <= 1'b1;
                    changed_q <= 1'b0;
                end
            end else if (ss_fall_q) begin
                state_q   <= S_CMD;
                bitcnt_q  <= 3'd0;
                miso_en_q <= 1'b0;
                miso_q    <= 1'b1;
            end else if (state_q != S_IDLE) begin
                if (sck_rise_q) begin
                    sh_q     <= byte_d;
                    bitcnt_q <= bitcnt_q + 3'd1;
                end
                if (byte_done) begin
                    case (state_q)
                        S_CMD: begin
                            case (byte_d[7:6])
                                2'b01: begin
                                    rd_mode_q <= byte_d[1];
                                    fixed_q   <= byte_d[2];
                                    if (byte_d[1]) begin
                                        state_q    <= S_RDATA;
                                        ks_q       <= KEYSCAN_i;
                                        fall_cnt_q <= 6'd0;
                                        miso_en_q  <= 1'b1;
                                        miso_q     <= 1'b1;
                                    end else begin
                                        state_q <= S_IGNORE;
                                    end
                                end
                                2'b11: begin
                                    addr_q  <= byte_d[3:0];
                                    state_q <= rd_mode_q ? S_IGNORE : S_WDATA;
                                end
                                2'b10: begin
                                    disp_on_q <= byte_d[3];
                                    bright_q  <= byte_d[2:0];
                                    changed_q <= 1'b1;
                                    state_q   <= S_IGNORE;
                                end
                                default: state_q <= S_IGNORE;
                            endcase
                        end
                        S_WDATA: begin
                            ram_q[ram_idx +: 8] <= byte_d;
                            changed_q           <= 1'b1;
                            if (!fixed_q) begin
                                addr_q <= addr_q + 4'd1;
                            end
                        end
                        default: ;
                    endcase
                end
                if ((state_q == S_RDATA) && sck_fall_q) begin
                    if (fall_cnt_q < 6'd32) begin
                        miso_q     <= ks_q[0];
                        ks_q       <= {1'b0, ks_q[31:1]};
                        fall_cnt_q <= fall_cnt_q + 6'd1;
                    end else begin
                        miso_en_q <= 1'b0;
                        miso_q    <= 1'b1;
                    end
                end
            end
        end
    end

    assign MISO_o     = miso_q;
    assign MISO_EN_o  = miso_en_q;
    assign DISP_RAM_o = ram_q;
    assign DISP_ON_o  = disp_on_q;
    assign BRIGHT_o   = bright_q;
    assign RD_MODE_o  = rd_mode_q;
    assign UPD_o      = upd_q;

endmodule

// File: tb/tb_tm1638_resp.sv
// Directed bench for tm1638_resp: master-side bit-banging of frames, with a
// queue of expected RAM images and read bytes checked as the DUT produces them.
`timescale 1ns/1ps
module tb_tm1638_resp;

    logic         ck;
    logic         xarst;
    logic         ss;
    logic         sclk;
    logic         mosi;
    logic         miso;
    logic         miso_en;
    logic [31:0]  keyscan;
    logic [127:0] disp_ram;
    logic         disp_on;
    logic [2:0]   bright;
    logic         rd_mode;
    logic         upd;

    tm1638_resp #(.C_SYNC_N(2)) dut (
        .CK_i       (ck),
        .XARST_i    (xarst),
        .SS_i       (ss),
        .SCLK_i     (sclk),
        .MOSI_i     (mosi),
        .MISO_o     (miso),
        .MISO_EN_o  (miso_en),
        .KEYSCAN_i  (keyscan),
        .DISP_RAM_o (disp_ram),
        .DISP_ON_o  (disp_on),
        .BRIGHT_o   (bright),
        .RD_MODE_o  (rd_mode),
        .UPD_o      (upd)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int n_assert = 0;
    int n_fail   = 0;
    int upd_hi   = 0;
    int en_in_rst = 0;

    logic [7:0]   mram[16];
    logic [127:0] ram_exp_q[$];
    logic [7:0]   rd_exp_q[$];

    always @(negedge ck) begin
        if (upd === 1'b1) upd_hi++;
        if (xarst === 1'b0 && miso_en !== 1'b0) en_in_rst++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge ck);
    endtask

    function automatic logic [127:0] pack_model();
        logic [127:0] r;
        for (int a = 0; a < 16; a++) r[8*a +: 8] = mram[a];
        return r;
    endfunction

    task automatic clear_model();
        for (int a = 0; a < 16; a++) mram[a] = 8'h00;
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = b[i];
            cyc(8);
            sclk = 1'b1;
            cyc(8);
        end
    endtask

    task automatic frame_begin();
        ss = 1'b0;
        cyc(8);
    endtask

    task automatic frame_end();
        cyc(4);
        ss = 1'b1;
        cyc(12);
    endtask

    task automatic frame1(input logic [7:0] b0);
        frame_begin();
        send_bits(b0, 8);
        frame_end();
    endtask

    task automatic pop_ram(input string tag);
        logic [127:0] e;
        if (ram_exp_q.size() == 0) begin
            check({tag, "_queue"}, 128'd0, 128'd1);
        end else begin
            e = ram_exp_q.pop_front();
            check(tag, disp_ram, e);
        end
    endtask

    initial begin
        int u0;
        logic [7:0] rx;
        xarst   = 1'b0;
        ss      = 1'b1;
        sclk    = 1'b1;
        mosi    = 1'b0;
        keyscan = 32'h0;
        clear_model();

        // Reset held while the pins wiggle.
        cyc(3);
        ss = 1'b0;
        send_bits(8'h42, 8);
        ss = 1'b1;
        cyc(4);
        check("rst_miso", miso, 1'b1);
        check("rst_miso_en", miso_en, 1'b0);
        check("rst_ram", disp_ram, 128'd0);
        check("rst_ctrl", {disp_on, bright, rd_mode, upd}, 6'd0);
        check("rst_en_never", en_in_rst, 0);
        xarst = 1'b1;
        cyc(10);
        check("rst_no_upd", upd_hi, 0);

        // Auto-increment write with address wrap.
        u0 = upd_hi;
        frame1(8'h40);
        check("upd_datacmd", upd_hi - u0, 0);
        mram[14] = 8'h11; mram[15] = 8'h22; mram[0] = 8'h33;
        ram_exp_q.push_back(pack_model());
        u0 = upd_hi;
        frame_begin();
        send_bits(8'hCE, 8); send_bits(8'h11, 8); send_bits(8'h22, 8); send_bits(8'h33, 8);
        frame_end();
        pop_ram("auto_inc");
        check("upd_auto_inc", upd_hi - u0, 1);

        // Fixed-address write.
        frame1(8'h44);
        mram[3] = 8'h55;
        ram_exp_q.push_back(pack_model());
        frame_begin();
        send_bits(8'hC3, 8); send_bits(8'hAA, 8); send_bits(8'h55, 8);
        frame_end();
        pop_ram("fixed");
        check("fixed_ram4", disp_ram[39:32], 8'h00);

        // Display control.
        u0 = upd_hi;
        frame1(8'h8D);
        check("ctrl_on", {disp_on, bright}, {1'b1, 3'd5});
        check("upd_ctrl", upd_hi - u0, 1);
        frame1(8'h80);
        check("ctrl_off", {disp_on, bright}, {1'b0, 3'd0});

        // Key read: 40 clocks, keyscan disturbed mid-stream.
        keyscan = 32'h8421_0F01;
        rd_exp_q.push_back(8'h01); rd_exp_q.push_back(8'h0F);
        rd_exp_q.push_back(8'h21); rd_exp_q.push_back(8'h84);
        frame_begin();
        send_bits(8'h42, 8);
        check("rd_en_entry", miso_en, 1'b1);
        rx = 8'h00;
        for (int i = 0; i < 40; i++) begin
            sclk = 1'b0;
            cyc(8);
            if (i == 10) keyscan = 32'hFFFF_FFFF;
            if (i < 32) begin
                rx = {miso, rx[7:1]};
                if (i % 8 == 7) begin
                    if (rd_exp_q.size() == 0) check("rd_queue", 1'b0, 1'b1);
                    else check($sformatf("rd_byte%0d", i / 8), rx, rd_exp_q.pop_front());
                end
            end
            if (i == 31) check("rd_en_fall32", miso_en, 1'b1);
            if (i == 32) check("rd_en_fall33", {miso_en, miso}, 2'b01);
            sclk = 1'b1;
            cyc(8);
        end
        frame_end();
        check("rd_mode", rd_mode, 1'b1);
        check("rd_idle_miso", {miso_en, miso}, 2'b01);

        // Address command in read mode leaves RAM alone.
        ram_exp_q.push_back(pack_model());
        u0 = upd_hi;
        frame_begin();
        send_bits(8'hC0, 8); send_bits(8'hFF, 8);
        frame_end();
        pop_ram("rdmode_nowrite");
        check("upd_rdmode", upd_hi - u0, 0);

        // Abort after 5 bits of a data byte.
        frame1(8'h40);
        ram_exp_q.push_back(pack_model());
        u0 = upd_hi;
        frame_begin();
        send_bits(8'hC0, 8); send_bits(8'h99, 5);
        frame_end();
        pop_ram("abort");
        check("abort_en", miso_en, 1'b0);
        check("upd_abort", upd_hi - u0, 0);
        frame1(8'h40);
        mram[1] = 8'h77;
        ram_exp_q.push_back(pack_model());
        frame_begin();
        send_bits(8'hC1, 8); send_bits(8'h77, 8);
        frame_end();
        pop_ram("after_abort");

        // Reset mid-frame with SS held low: rest of that frame is ignored.
        frame_begin();
        send_bits(8'hC5, 8); send_bits(8'h3C, 4);
        xarst = 1'b0;
        cyc(3);
        check("midrst_ram", disp_ram, 128'd0);
        xarst = 1'b1;
        send_bits(8'h3C, 4); send_bits(8'h66, 8);
        u0 = upd_hi;
        frame_end();
        clear_model();
        ram_exp_q.push_back(pack_model());
        pop_ram("midrst_ignored");
        check("upd_midrst", upd_hi - u0, 0);
        mram[2] = 8'h5A;
        ram_exp_q.push_back(pack_model());
        frame_begin();
        send_bits(8'hC2, 8); send_bits(8'h5A, 8);
        frame_end();
        pop_ram("post_rst_write");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
